// File: rtl/mmu_arbiter.sv
// Arbitrates the single mmu master port between instruction fetch (read-only word) and
// data load/store. The winning request is registered onto mmu_*, and stuck accesses time out.
module mmu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8,
  parameter bit          FAIRNESS       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_address,
  output logic [31:0] if_data_out,
  output logic        if_ready,
  output logic        if_error,
  input  logic        d_req_read,
  input  logic        d_req_write,
  input  logic        d_signed,
  input  logic [1:0]  d_width,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_in,
  output logic [31:0] d_data_out,
  output logic        d_ready,
  output logic        d_error,
  output logic        mmu_read_enable,
  output logic        mmu_write_enable,
  output logic        mmu_signed_read,
  output logic [1:0]  mmu_data_width,
  output logic [31:0] mmu_address,
  output logic [31:0] mmu_data_in,
  input  logic [31:0] mmu_data_out,
  input  logic        mmu_ready,
  output logic        busy,
  output logic        owner
);

  // Word access encoding of the mmu data-width field.
  localparam logic [1:0]           WIDTH_WORD = 2'd2;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RELEASE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_owner;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 w_d_any;
  logic                 w_grant;
  logic                 w_grant_d;
  logic                 w_done;
  logic                 w_timeout;

  assign w_d_any = d_req_read | d_req_write;
  assign busy    = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (if_req || w_d_any) begin
          w_grant     = 1'b1;
          // On a tie D wins unless round-robin says D was served last.
          w_grant_d   = w_d_any && (!if_req || !FAIRNESS || !r_last_owner);
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mmu_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_owner     <= 1'b0;
      r_cnt            <= '0;
      owner            <= 1'b0;
      mmu_read_enable  <= 1'b0;
      mmu_write_enable <= 1'b0;
      mmu_signed_read  <= 1'b0;
      mmu_data_width   <= '0;
      mmu_address      <= '0;
      mmu_data_in      <= '0;
      if_data_out      <= '0;
      d_data_out       <= '0;
      if_ready         <= 1'b0;
      if_error         <= 1'b0;
      d_ready          <= 1'b0;
      d_error          <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      if_error <= 1'b0;
      d_ready  <= 1'b0;
      d_error  <= 1'b0;

      if (w_grant) begin
        owner        <= w_grant_d;
        r_last_owner <= w_grant_d;
        r_cnt        <= '0;
        if (w_grant_d) begin
          mmu_read_enable  <= ~d_req_write;
          mmu_write_enable <= d_req_write;
          mmu_signed_read  <= d_signed;
          mmu_data_width   <= d_width;
          mmu_address      <= d_address;
          mmu_data_in      <= d_data_in;
        end else begin
          mmu_read_enable  <= 1'b1;
          mmu_write_enable <= 1'b0;
          mmu_signed_read  <= 1'b0;
          mmu_data_width   <= WIDTH_WORD;
          mmu_address      <= if_address;
          mmu_data_in      <= '0;
        end
      end

      if (r_state == ST_ACCESS && !w_done && !w_timeout) begin
        r_cnt <= r_cnt + TIMEOUT_W'(1);
      end

      if (w_done) begin
        mmu_read_enable  <= 1'b0;
        mmu_write_enable <= 1'b0;
        if (owner) begin
          d_ready <= 1'b1;
          if (mmu_read_enable) d_data_out <= mmu_data_out;
        end else begin
          if_ready    <= 1'b1;
          if_data_out <= mmu_data_out;
        end
      end

      if (w_timeout) begin
        mmu_read_enable  <= 1'b0;
        mmu_write_enable <= 1'b0;
        if (owner) d_error  <= 1'b1;
        else       if_error <= 1'b1;
      end
    end
  end

endmodule
